conv_ctrl: RTL and testbench

Sequencer for the two-layer convolution datapath `conv_dp`. It accepts a run request and image/filter dimensions. It drives the layer-1 memory load, layer-1 PE pass, layer-2 write-back/load and layer-2 PE pass strictly in order, waiting on each stage's done. A per-stage watchdog converts a hung stage into a sticky error.

---
 rtl/conv_ctrl_pkg.sv | 36 +++
 rtl/conv_ctrl_stage_timer.sv | 39 +++
 rtl/conv_ctrl.sv | 174 +++++++++++++++++
 tb/tb_conv_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the two-layer convolution sequencer.
// State encodings are exported on the stage port, so they are fixed here.
package conv_ctrl_pkg;

   localparam int unsigned DIM_W = 8;

   typedef enum logic [3:0] {
      StIdle   = 4'h0,
      StL1Mem  = 4'h1,
      StL1MemW = 4'h2,
      StL1Pe   = 4'h3,
      StL1PeW  = 4'h4,
      StL2Wr   = 4'h5,
      StL2Mem  = 4'h6,
      StL2MemW = 4'h7,
      StL2Pe   = 4'h8,
      StL2PeW  = 4'h9,
      StFin    = 4'hA,
      StErr    = 4'hF
   } state_t;

   // A filter must be non-empty and no larger than the image it slides over.
   function automatic logic cfg_bad(input logic [DIM_W-1:0] cx, input logic [DIM_W-1:0] cy);
      return (cy == '0) || (cy > cx);
   endfunction

   function automatic logic [DIM_W-1:0] calc_z(input logic [DIM_W-1:0] cx,
                                               input logic [DIM_W-1:0] cy);
      return cx - cy + DIM_W'(1);
   endfunction

   function automatic logic is_wait(input state_t st);
      return (st == StL1MemW) || (st == StL1PeW) || (st == StL2MemW) || (st == StL2PeW);
   endfunction

endpackage

// File: rtl/conv_ctrl_stage_timer.sv
// Per-stage watchdog: counts cycles spent in a wait state and flags the last
// permitted cycle so the sequencer can bail out to the error state.
module stage_timer #(
   parameter int unsigned    TO_W    = 16,
   parameter logic [TO_W-1:0] TIMEOUT = {TO_W{1'b1}}
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            en,
   output logic [TO_W-1:0] count,
   output logic            expired
);

   logic [TO_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != {TO_W{1'b1}})) begin
         count_d = count_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the cycles already spent, so the current cycle is the
   // TIMEOUT-th one when count_q == TIMEOUT-1.
   assign count   = count_q;
   assign expired = en && (count_q >= (TIMEOUT - TO_W'(1)));

endmodule

// File: rtl/conv_ctrl.sv
// Sequencer for conv_dp: layer-1 load, layer-1 PE pass, layer-2 write-back and
// load, layer-2 PE pass, each gated on its done and guarded by a watchdog.
module conv_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned     TO_W    = 16,
   parameter logic [TO_W-1:0] TIMEOUT = {TO_W{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [DIM_W-1:0] cfg_x,
   input  logic [DIM_W-1:0] cfg_y,
   input  logic             done_mem_l1,
   input  logic             done_pe_l1,
   input  logic             done_mem_l2,
   input  logic             done_pe_l2,
   output logic             start_mem_l1,
   output logic             start_pe_l1,
   output logic             start_mem_l2,
   output logic             start_pe_l2,
   output logic             wrmem_en_l2,
   output logic [DIM_W-1:0] x,
   output logic [DIM_W-1:0] y,
   output logic [DIM_W-1:0] z,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       stage
);

   state_t           state_q, state_d;
   logic [DIM_W-1:0] x_q, x_d;
   logic [DIM_W-1:0] y_q, y_d;
   logic [DIM_W-1:0] z_q, z_d;
   logic             err_q, err_d;

   logic            in_wait;
   logic            wd_expired;
   logic [TO_W-1:0] wd_count;
   logic            unused_wd_count;

   assign in_wait         = is_wait(state_q);
   assign unused_wd_count = ^wd_count;

   // Wait states are only entered from pulse states, so holding the counter
   // clear outside them guarantees a zero count on every wait-state entry.
   stage_timer #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_stage_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_wait),
      .en      (in_wait),
      .count   (wd_count),
      .expired (wd_expired)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      err_d   = err_q;

      if (abort) begin
         state_d = StIdle;
         err_d   = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StErr: begin
               if (start) begin
                  x_d = cfg_x;
                  y_d = cfg_y;
                  z_d = calc_z(cfg_x, cfg_y);
                  if (cfg_bad(cfg_x, cfg_y)) begin
                     state_d = StErr;
                     err_d   = 1'b1;
                  end else begin
                     state_d = StL1Mem;
                     err_d   = 1'b0;
                  end
               end
            end
            StL1Mem: state_d = StL1MemW;
            StL1MemW: begin
               if (done_mem_l1) begin
                  state_d = StL1Pe;
               end else if (wd_expired) begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end
            end
            StL1Pe: state_d = StL1PeW;
            StL1PeW: begin
               if (done_pe_l1) begin
                  state_d = StL2Wr;
               end else if (wd_expired) begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end
            end
            StL2Wr:  state_d = StL2Mem;
            StL2Mem: state_d = StL2MemW;
            StL2MemW: begin
               if (done_mem_l2) begin
                  state_d = StL2Pe;
               end else if (wd_expired) begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end
            end
            StL2Pe: state_d = StL2PeW;
            StL2PeW: begin
               if (done_pe_l2) begin
                  state_d = StFin;
               end else if (wd_expired) begin
                  state_d = StErr;
                  err_d   = 1'b1;
               end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // Output decode
   always_comb begin
      start_mem_l1 = 1'b0;
      start_pe_l1  = 1'b0;
      start_mem_l2 = 1'b0;
      start_pe_l2  = 1'b0;
      wrmem_en_l2  = 1'b0;
      done         = 1'b0;
      busy         = (state_q != StIdle) && (state_q != StErr);
      unique case (state_q)
         StL1Mem: start_mem_l1 = 1'b1;
         StL1Pe:  start_pe_l1  = 1'b1;
         StL2Wr:  wrmem_en_l2  = 1'b1;
         StL2Mem: start_mem_l2 = 1'b1;
         StL2Pe:  start_pe_l2  = 1'b1;
         StFin:   done         = 1'b1;
         default: ;
      endcase
   end

   assign x     = x_q;
   assign y     = y_q;
   assign z     = z_q;
   assign err   = err_q;
   assign stage = state_q;

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: config table plus scoreboarded pulse/done/err events,
// with a done responder whose per-stage delay is programmable.
module tb_conv_ctrl;
   import conv_ctrl_pkg::*;

   localparam int unsigned TMO = 24;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] cfg_x = '0;
   logic [7:0] cfg_y = '0;
   logic       done_mem_l1, done_pe_l1, done_mem_l2, done_pe_l2;
   logic       start_mem_l1, start_pe_l1, start_mem_l2, start_pe_l2, wrmem_en_l2;
   logic [7:0] x, y, z;
   logic       busy, done, err;
   logic [3:0] stage;

   conv_ctrl #(
      .TO_W    (16),
      .TIMEOUT (16'(TMO))
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .cfg_x        (cfg_x),
      .cfg_y        (cfg_y),
      .done_mem_l1  (done_mem_l1),
      .done_pe_l1   (done_pe_l1),
      .done_mem_l2  (done_mem_l2),
      .done_pe_l2   (done_pe_l2),
      .start_mem_l1 (start_mem_l1),
      .start_pe_l1  (start_pe_l1),
      .start_mem_l2 (start_mem_l2),
      .start_pe_l2  (start_pe_l2),
      .wrmem_en_l2  (wrmem_en_l2),
      .x            (x),
      .y            (y),
      .z            (z),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .stage        (stage)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Done responder: after a start pulse the matching done stays low for
   // d_dly[i] extra wait cycles, otherwise it is held high (stale-high case).
   int         d_dly [4] = '{0, 0, 0, 0};
   int         rem   [4] = '{0, 0, 0, 0};
   logic [3:0] dn = 4'hF;
   logic [3:0] pv;
   assign pv = {start_pe_l2, start_mem_l2, start_pe_l1, start_mem_l1};
   assign done_mem_l1 = dn[0];
   assign done_pe_l1  = dn[1];
   assign done_mem_l2 = dn[2];
   assign done_pe_l2  = dn[3];

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pv[i]) begin
            rem[i] <= d_dly[i];
            dn[i]  <= (d_dly[i] == 0);
         end else begin
            dn[i] <= (rem[i] == 0);
            if (rem[i] > 0) rem[i] <= rem[i] - 1;
         end
      end
   end

   // Scoreboard: codes 0..4 = mem_l1, pe_l1, wrmem_l2, mem_l2, pe_l2; 5 = done; 6 = err rise
   typedef struct {
      int code;
      int at;
   } ev_t;
   ev_t  exp_q[$];
   logic err_prev = 1'b0;

   task automatic push_ev(input int code, input int at);
      ev_t e;
      e.code = code;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic push_run(input int s, input int d0, input int d1, input int d2, input int d3);
      push_ev(0, s + 1);
      push_ev(1, s + 3 + d0);
      push_ev(2, s + 5 + d0 + d1);
      push_ev(3, s + 6 + d0 + d1);
      push_ev(4, s + 8 + d0 + d1 + d2);
      push_ev(5, s + 10 + d0 + d1 + d2 + d3);
   endtask

   always @(negedge clk) begin
      int  code;
      ev_t e;
      code = -1;
      if (start_mem_l1)         code = 0;
      else if (start_pe_l1)     code = 1;
      else if (wrmem_en_l2)     code = 2;
      else if (start_mem_l2)    code = 3;
      else if (start_pe_l2)     code = 4;
      else if (done)            code = 5;
      else if (err && !err_prev) code = 6;
      err_prev <= err;
      if (code >= 0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event: got code %0d at cycle %0d, expected none", code, cyc);
         end else begin
            e = exp_q.pop_front();
            check("event code", code, e.code);
            check("event cycle", cyc, e.at);
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives a one-cycle start; s is the cycle in which start is sampled.
   task automatic do_start(input logic [7:0] cx, input logic [7:0] cy, output int s);
      @(negedge clk);
      cfg_x = cx;
      cfg_y = cy;
      start = 1'b1;
      s     = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   typedef struct {
      logic [7:0] cx;
      logic [7:0] cy;
      logic       e_err;
      logic [7:0] e_z;
      state_t     e_st;
   } vec_t;
   vec_t vt[8];

   initial begin
      int s;

      vt[0] = '{8'd16,  8'd4,   1'b0, 8'd13,  StL1Mem};
      vt[1] = '{8'd4,   8'd5,   1'b1, 8'd0,   StErr};
      vt[2] = '{8'd5,   8'd5,   1'b0, 8'd1,   StL1Mem};
      vt[3] = '{8'd7,   8'd0,   1'b1, 8'd8,   StErr};
      vt[4] = '{8'd255, 8'd1,   1'b0, 8'd255, StL1Mem};
      vt[5] = '{8'd1,   8'd1,   1'b0, 8'd1,   StL1Mem};
      vt[6] = '{8'd3,   8'd200, 1'b1, 8'd60,  StErr};
      vt[7] = '{8'd0,   8'd0,   1'b1, 8'd1,   StErr};

      // Reset values
      #2 rst_n = 1'b0;
      #3;
      check("reset stage", int'(stage), int'(StIdle));
      check("reset busy", int'(busy), 0);
      check("reset err", int'(err), 0);
      check("reset done", int'(done), 0);
      check("reset xyz", int'({x, y, z}), 0);
      check("reset pulses", int'({start_mem_l1, start_pe_l1, start_mem_l2, start_pe_l2,
                                  wrmem_en_l2}), 0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(2);

      // Config table: one start each, inspect, then abort back to idle
      for (int i = 0; i < 8; i++) begin
         do_start(vt[i].cx, vt[i].cy, s);
         push_ev(vt[i].e_err ? 6 : 0, s + 1);
         check("tbl stage", int'(stage), int'(vt[i].e_st));
         check("tbl err", int'(err), int'(vt[i].e_err));
         check("tbl x", int'(x), int'(vt[i].cx));
         check("tbl y", int'(y), int'(vt[i].cy));
         check("tbl z", int'(z), int'(vt[i].e_z));
         do_abort();
         check("tbl abort stage", int'(stage), int'(StIdle));
         check("tbl abort err", int'(err), 0);
         wait_cyc(2);
      end

      // Normal run, dones held high throughout
      do_start(8'd16, 8'd4, s);
      push_run(s, 0, 0, 0, 0);
      check("run busy", int'(busy), 1);
      wait_cyc(10);
      check("run idle", int'(stage), int'(StIdle));
      check("run busy end", int'(busy), 0);
      check("run z", int'(z), 13);

      // Delayed layer-1 PE done
      d_dly[1] = 20;
      do_start(8'd16, 8'd4, s);
      push_run(s, 0, 20, 0, 0);
      wait_cyc(32);
      d_dly[1] = 0;
      check("delay idle", int'(stage), int'(StIdle));

      // Done on the last permitted watchdog cycle wins
      d_dly[2] = TMO - 1;
      do_start(8'd16, 8'd4, s);
      push_run(s, 0, 0, TMO - 1, 0);
      wait_cyc(TMO + 12);
      d_dly[2] = 0;
      check("wd edge err", int'(err), 0);

      // Watchdog expiry in L2_MEM_W
      d_dly[2] = TMO + 4;
      do_start(8'd16, 8'd4, s);
      push_ev(0, s + 1);
      push_ev(1, s + 3);
      push_ev(2, s + 5);
      push_ev(3, s + 6);
      push_ev(6, s + 7 + TMO);
      wait_cyc(TMO + 7);
      check("wd stage", int'(stage), int'(StErr));
      check("wd err", int'(err), 1);
      check("wd busy", int'(busy), 0);
      wait_cyc(8);
      d_dly[2] = 0;
      do_abort();
      wait_cyc(2);

      // Bad config, then a good start from ERR clears err and runs
      do_start(8'd4, 8'd5, s);
      push_ev(6, s + 1);
      wait_cyc(3);
      check("bad stage", int'(stage), int'(StErr));
      do_start(8'd16, 8'd4, s);
      push_run(s, 0, 0, 0, 0);
      check("recover err", int'(err), 0);
      wait_cyc(10);
      check("recover idle", int'(stage), int'(StIdle));

      // Abort while waiting on the layer-1 PE
      d_dly[1] = 5;
      do_start(8'd16, 8'd4, s);
      push_ev(0, s + 1);
      push_ev(1, s + 3);
      wait_cyc(4);
      check("abort pre stage", int'(stage), int'(StL1PeW));
      do_abort();
      check("abort stage", int'(stage), int'(StIdle));
      check("abort busy", int'(busy), 0);
      check("abort x", int'(x), 16);
      d_dly[1] = 0;
      wait_cyc(8);

      // Start while busy is ignored
      do_start(8'd16, 8'd4, s);
      push_run(s, 0, 0, 0, 0);
      wait_cyc(3);
      cfg_x = 8'd4;
      cfg_y = 8'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc(8);
      check("busy start x", int'(x), 16);
      check("busy start z", int'(z), 13);
      check("busy start err", int'(err), 0);

      // Asynchronous reset while waiting on the layer-2 PE
      d_dly[3] = 5;
      do_start(8'd16, 8'd4, s);
      push_ev(0, s + 1);
      push_ev(1, s + 3);
      push_ev(2, s + 5);
      push_ev(3, s + 6);
      push_ev(4, s + 8);
      wait_cyc(9);
      #2 rst_n = 1'b0;
      #1;
      check("rst stage", int'(stage), int'(StIdle));
      check("rst busy", int'(busy), 0);
      check("rst xyz", int'({x, y, z}), 0);
      check("rst flags", int'({done, err, start_pe_l2}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      d_dly[3] = 0;
      wait_cyc(15);
      check("rst after stage", int'(stage), int'(StIdle));

      check("scoreboard empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
